// File: rtl/button_irq_sequencer.sv
// Avalon-MM master for the 2-bit push-button PIO: mask setup, irq service,
// debounced edge_capture clearing and a timestamped event FIFO.
module button_irq_sequencer #(
    parameter logic [1:0] INIT_MASK      = 2'b11,
    parameter int         HOLDOFF_CYCLES = 50000,
    parameter int         TS_W           = 16,
    parameter int         DEPTH          = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [1:0]      m_address,
    output logic            m_chipselect,
    output logic            m_write_n,
    output logic [31:0]     m_writedata,
    input  logic [31:0]     m_readdata,
    input  logic            pio_irq,
    input  logic            cfg_wr,
    input  logic [1:0]      cfg_mask,
    output logic            evt_valid,
    output logic [TS_W+1:0] evt_data,
    input  logic            evt_ready,
    output logic            overflow,
    input  logic            ovf_clr,
    output logic            busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int EW = TS_W + 2;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_INIT =
        (HOLDOFF_CYCLES > 0) ? HW'(HOLDOFF_CYCLES - 1) : '0;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_EDGE = 2'd3;

    typedef enum logic [3:0] {
        RST_MASK,
        RST_CLR,
        IDLE,
        WR_MASK,
        RD_ADDR,
        RD_WAIT,
        WR_CLR,
        PUSH,
        HOLD,
        WR_CLR2
    } state_t;

    state_t state, state_n;

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] ts_lat;
    logic [1:0]      cur_mask;
    logic [1:0]      edges;
    logic            pend_valid;
    logic [1:0]      pend_mask;
    logic [HW-1:0]   hold_cnt;

    logic            bus_cs;
    logic            bus_wn;
    logic [1:0]      bus_addr;
    logic [31:0]     bus_wdata;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;
    logic            full;
    logic            accept;
    logic            unused_rd;

    assign unused_rd = ^m_readdata[31:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST_MASK;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        bus_cs    = 1'b0;
        bus_wn    = 1'b1;
        bus_addr  = 2'd0;
        bus_wdata = 32'd0;
        unique case (state)
            RST_MASK: begin
                bus_cs    = 1'b1;
                bus_wn    = 1'b0;
                bus_addr  = A_MASK;
                bus_wdata = {30'd0, INIT_MASK};
                state_n   = RST_CLR;
            end
            RST_CLR: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = A_EDGE;
                state_n  = IDLE;
            end
            IDLE: begin
                // A cfg_wr arriving this cycle already beats the irq
                if (pend_valid || cfg_wr) begin
                    state_n = WR_MASK;
                end else if (pio_irq) begin
                    state_n = RD_ADDR;
                end
            end
            WR_MASK: begin
                bus_cs    = 1'b1;
                bus_wn    = 1'b0;
                bus_addr  = A_MASK;
                bus_wdata = {30'd0, pend_mask};
                state_n   = IDLE;
            end
            RD_ADDR: begin
                bus_cs   = 1'b1;
                bus_addr = A_EDGE;
                state_n  = RD_WAIT;
            end
            RD_WAIT: begin
                state_n = WR_CLR;
            end
            WR_CLR: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = A_EDGE;
                state_n  = PUSH;
            end
            PUSH: begin
                if (edges != 2'b00 && HOLDOFF_CYCLES > 0) begin
                    state_n = HOLD;
                end else begin
                    state_n = IDLE;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_n = WR_CLR2;
                end
            end
            WR_CLR2: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = A_EDGE;
                state_n  = IDLE;
            end
            default: begin
                state_n = RST_MASK;
            end
        endcase
    end

    // Reset abandons any access in flight, even though the state is RST_MASK
    assign m_chipselect = bus_cs & ~reset;
    assign m_write_n    = bus_wn | reset;
    assign m_address    = reset ? 2'd0 : bus_addr;
    assign m_writedata  = reset ? 32'd0 : bus_wdata;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            ts       <= '0;
            ts_lat   <= '0;
            cur_mask <= 2'b00;
            edges    <= 2'b00;
            hold_cnt <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            if (state == IDLE && state_n == RD_ADDR) begin
                ts_lat <= ts;
            end
            if (state == RST_MASK) begin
                cur_mask <= INIT_MASK;
            end else if (state == WR_MASK) begin
                cur_mask <= pend_mask;
            end
            if (state == RD_WAIT) begin
                edges <= m_readdata[1:0] & cur_mask;
            end
            if (state == PUSH) begin
                hold_cnt <= HOLD_INIT;
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

    // Last cfg_wr wins; a new request during WR_MASK stays pending
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_mask  <= 2'b00;
        end else if (cfg_wr) begin
            pend_valid <= 1'b1;
            pend_mask  <= cfg_mask;
        end else if (state == WR_MASK) begin
            pend_valid <= 1'b0;
        end
    end

    assign push      = (state == PUSH) && (edges != 2'b00);
    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    assign full      = (count == FULL_CNT);
    assign accept    = push && (!full || pop);
    assign evt_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {ts_lat, edges};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (accept && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !accept) begin
                count <= count - (AW + 1)'(1);
            end
            if (push && !accept) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_irq_sequencer.sv
// Directed bench for button_irq_sequencer with a behavioural PIO read port.
module tb_button_irq_sequencer;

    localparam int TS_W = 8;
    localparam int EW   = TS_W + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    m_address;
    logic          m_chipselect;
    logic          m_write_n;
    logic [31:0]   m_writedata;
    logic [31:0]   m_readdata = '0;
    logic          pio_irq;
    logic          cfg_wr;
    logic [1:0]    cfg_mask;
    logic          evt_valid;
    logic [EW-1:0] evt_data;
    logic          evt_ready;
    logic          overflow;
    logic          ovf_clr;
    logic          busy;

    logic [1:0]      edge_cap;
    logic [TS_W-1:0] ts_model = '0;
    int n_cmp = 0;
    int n_err = 0;

    button_irq_sequencer #(
        .INIT_MASK(2'b11),
        .HOLDOFF_CYCLES(4),
        .TS_W(TS_W),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .m_address(m_address),
        .m_chipselect(m_chipselect),
        .m_write_n(m_write_n),
        .m_writedata(m_writedata),
        .m_readdata(m_readdata),
        .pio_irq(pio_irq),
        .cfg_wr(cfg_wr),
        .cfg_mask(cfg_mask),
        .evt_valid(evt_valid),
        .evt_data(evt_data),
        .evt_ready(evt_ready),
        .overflow(overflow),
        .ovf_clr(ovf_clr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // PIO edge_capture read with one cycle of latency
    always @(posedge clk) begin
        if (m_chipselect && m_write_n && m_address == 2'd3)
            m_readdata <= {30'd0, edge_cap};
        ts_model <= reset ? '0 : ts_model + 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [1:0] a,
                          input logic [31:0] d);
        chk({tag, "_cs"}, 32'(m_chipselect), 32'd1);
        chk({tag, "_wn"}, 32'(m_write_n), 32'd0);
        chk({tag, "_addr"}, 32'(m_address), 32'(a));
        chk({tag, "_data"}, m_writedata, d);
    endtask

    task automatic service(input logic [1:0] e, input logic rdy,
                           output logic [TS_W-1:0] ts_o);
        edge_cap = e;
        pio_irq  = 1'b1;
        ts_o     = ts_model;
        step();
        pio_irq = 1'b0;
        step();
        step();
        step();
        evt_ready = rdy;
        step();
        evt_ready = 1'b0;
        for (int k = 0; k < 20 && busy; k++) step();
        chk("svc_idle", 32'(busy), 32'd0);
    endtask

    logic [TS_W-1:0] t0;
    logic [EW-1:0]   exp_q [5];

    initial begin
        reset     = 1'b1;
        pio_irq   = 1'b0;
        cfg_wr    = 1'b0;
        cfg_mask  = 2'b00;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        edge_cap  = 2'b00;
        step();
        step();
        chk("rst_cs", 32'(m_chipselect), 32'd0);
        chk("rst_wn", 32'(m_write_n), 32'd1);
        chk("rst_addr", 32'(m_address), 32'd0);
        chk("rst_wdata", m_writedata, 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        reset = 1'b0;
        #1;
        chk_wr("init_mask", 2'd2, 32'd3);
        step();
        chk_wr("init_clr", 2'd3, 32'd0);
        chk("init_busy", 32'(busy), 32'd1);
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_cs", 32'(m_chipselect), 32'd0);

        // single event, hold-off of 4 cycles
        edge_cap = 2'b01;
        pio_irq  = 1'b1;
        t0       = ts_model;
        step();
        pio_irq = 1'b0;
        chk("rd_cs", 32'(m_chipselect), 32'd1);
        chk("rd_wn", 32'(m_write_n), 32'd1);
        chk("rd_addr", 32'(m_address), 32'd3);
        step();
        chk("rdw_cs", 32'(m_chipselect), 32'd0);
        step();
        chk_wr("clr", 2'd3, 32'd0);
        step();
        chk("push_valid", 32'(evt_valid), 32'd0);
        step();
        chk("evt_valid", 32'(evt_valid), 32'd1);
        chk("evt_data", 32'(evt_data), 32'({t0, 2'b01}));
        step();
        step();
        step();
        chk("hold_cs", 32'(m_chipselect), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        step();
        chk_wr("clr2", 2'd3, 32'd0);
        step();
        chk("post_busy", 32'(busy), 32'd0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("pop_empty", 32'(evt_valid), 32'd0);

        // cfg beats irq, then spurious edge under new mask
        cfg_wr   = 1'b1;
        cfg_mask = 2'b10;
        pio_irq  = 1'b1;
        edge_cap = 2'b01;
        step();
        cfg_wr = 1'b0;
        chk_wr("cfg_mask", 2'd2, 32'd2);
        step();
        chk("cfg_idle", 32'(busy), 32'd0);
        step();
        pio_irq = 1'b0;
        chk("sp_rd_cs", 32'(m_chipselect), 32'd1);
        chk("sp_rd_wn", 32'(m_write_n), 32'd1);
        step();
        step();
        chk_wr("sp_clr", 2'd3, 32'd0);
        step();
        step();
        chk("sp_busy", 32'(busy), 32'd0);
        chk("sp_valid", 32'(evt_valid), 32'd0);

        // fill FIFO then overflow
        for (int i = 0; i < 5; i++) begin
            service(2'b11, 1'b0, t0);
            exp_q[i] = {t0, 2'b10};
            if (i == 3) chk("full_ovf", 32'(overflow), 32'd0);
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(evt_data), 32'(exp_q[0]));
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // full FIFO with pop during PUSH
        service(2'b10, 1'b1, t0);
        exp_q[4] = {t0, 2'b10};
        chk("fp_ovf", 32'(overflow), 32'd0);
        for (int j = 1; j < 5; j++) begin
            chk("fp_valid", 32'(evt_valid), 32'd1);
            chk("fp_order", 32'(evt_data), 32'(exp_q[j]));
            evt_ready = 1'b1;
            step();
            evt_ready = 1'b0;
        end
        chk("fp_empty", 32'(evt_valid), 32'd0);

        // reset during HOLD
        edge_cap = 2'b10;
        pio_irq  = 1'b1;
        step();
        pio_irq = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("hr_valid", 32'(evt_valid), 32'd1);
        chk("hr_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("hr_flush", 32'(evt_valid), 32'd0);
        chk_wr("hr_mask", 2'd2, 32'd3);
        step();
        step();
        chk("hr_idle", 32'(busy), 32'd0);

        // timestamp rollover
        for (int k = 0; k < 300 && ts_model != 8'd255; k++) step();
        chk("ts_reach", 32'(ts_model), 32'd255);
        service(2'b01, 1'b0, t0);
        service(2'b01, 1'b0, t0);
        chk("ts_ff", 32'(evt_data), 32'({8'hFF, 2'b01}));
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("ts_wrap", 32'(evt_data), 32'({8'd9, 2'b01}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
